// File: rtl/fifo_block_packer_if.sv
// Read-side bus of the store-buffer FIFO packer: FIFO pop port, flush
// request and the wide block valid/ready handshake towards the crypto core.
interface fifo_block_packer_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int WORDS_PER_BLOCK = 4
);
    localparam int CNT_W = $clog2(WORDS_PER_BLOCK + 1);

    logic [DATA_WIDTH-1:0]                 fifo_rd_data_i;
    logic                                  fifo_empty_i;
    logic                                  fifo_rd_en_o;
    logic                                  flush_i;
    logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] blk_data_o;
    logic [CNT_W-1:0]                      blk_nwords_o;
    logic                                  blk_valid_o;
    logic                                  blk_ready_i;

    // Packer side
    modport master (
        input  fifo_rd_data_i, fifo_empty_i, flush_i, blk_ready_i,
        output fifo_rd_en_o, blk_data_o, blk_nwords_o, blk_valid_o
    );

    // FIFO / crypto-core side
    modport slave (
        output fifo_rd_data_i, fifo_empty_i, flush_i, blk_ready_i,
        input  fifo_rd_en_o, blk_data_o, blk_nwords_o, blk_valid_o
    );
endinterface

// File: rtl/fifo_block_packer.sv
// Pops words from the FIFO's registered read port (one per cycle, fully
// pipelined) and packs WORDS_PER_BLOCK of them into one wide block. A flush
// emits the current partial block zero-padded; empty flushes are dropped.
module fifo_block_packer #(
    parameter int DATA_WIDTH      = 32,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    fifo_block_packer_if.master    bus
);
    localparam int CNT_W = $clog2(WORDS_PER_BLOCK + 1);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORDS_PER_BLOCK);

    logic [1:0]            state;
    logic [CNT_W-1:0]      wcnt;
    logic [CNT_W-1:0]      wcnt_inc;
    logic                  pend;
    logic                  flush_pend;
    logic                  blk_valid;
    logic [CNT_W-1:0]      blk_nwords;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] slot [WORDS_PER_BLOCK];

    // Pop gating: only in FILL, never on empty, and never more pops than
    // free slots counting the word still in flight.
    always_comb begin
        wcnt_inc = wcnt + CNT_W'(1);
        rd_en    = rst && (state == S_FILL) && !flush_pend && !bus.fifo_empty_i &&
                   (({1'b0, wcnt} + (CNT_W+1)'(pend)) < (CNT_W+1)'(WORDS_PER_BLOCK));
    end

    // Control FSM, word capture into slots, and block output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_FILL;
            wcnt       <= '0;
            pend       <= 1'b0;
            flush_pend <= 1'b0;
            blk_valid  <= 1'b0;
            blk_nwords <= '0;
            for (int unsigned i = 0; i < WORDS_PER_BLOCK; i++) slot[i] <= '0;
        end else begin
            pend <= rd_en;
            case (state)
                S_FILL: begin
                    if (pend) begin
                        for (int unsigned i = 0; i < WORDS_PER_BLOCK; i++)
                            if (wcnt == CNT_W'(i)) slot[i] <= bus.fifo_rd_data_i;
                        wcnt <= wcnt_inc;
                    end
                    // A flush coinciding with the final capture stays latched
                    // and is handled after the full block is taken.
                    if (bus.flush_i) flush_pend <= 1'b1;
                    if (pend && (wcnt_inc == FULL_CNT)) begin
                        state      <= S_OUT;
                        blk_valid  <= 1'b1;
                        blk_nwords <= FULL_CNT;
                    end else if (flush_pend || bus.flush_i) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pend) begin
                        for (int unsigned i = 0; i < WORDS_PER_BLOCK; i++)
                            if (wcnt == CNT_W'(i)) slot[i] <= bus.fifo_rd_data_i;
                        wcnt <= wcnt_inc;
                    end else begin
                        flush_pend <= 1'b0;
                        if (wcnt != '0) begin
                            state      <= S_OUT;
                            blk_valid  <= 1'b1;
                            blk_nwords <= wcnt;
                        end else begin
                            state <= S_FILL;
                        end
                    end
                end
                S_OUT: begin
                    if (bus.flush_i) flush_pend <= 1'b1;
                    if (blk_valid && bus.blk_ready_i) begin
                        state     <= S_FILL;
                        blk_valid <= 1'b0;
                        wcnt      <= '0;
                        for (int unsigned i = 0; i < WORDS_PER_BLOCK; i++) slot[i] <= '0;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

    // Flatten slots into the block bus, word 0 in the low bits.
    always_comb begin
        bus.blk_data_o = '0;
        for (int unsigned i = 0; i < WORDS_PER_BLOCK; i++)
            bus.blk_data_o[i*DATA_WIDTH +: DATA_WIDTH] = slot[i];
    end

    assign bus.fifo_rd_en_o = rd_en;
    assign bus.blk_valid_o  = blk_valid;
    assign bus.blk_nwords_o = blk_nwords;
endmodule

// File: tb/tb_fifo_block_packer.sv
// Testbench for fifo_block_packer: a queue-based FIFO model with a registered
// read port feeds the DUT; a word-stream scoreboard checks every accepted block
// plus directed latency, back-pressure, flush, trickle and reset scenarios.
module tb_fifo_block_packer;
    localparam int DW = 32;
    localparam int W  = 4;

    logic clk = 1'b0;
    logic rst;
    logic push_en = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic rst_prev = 1'b1;

    logic [DW-1:0] fq[$];     // FIFO contents
    logic [DW-1:0] exp_q[$];  // words expected out of the packer, in order

    int n_cmp = 0;
    int n_err = 0;

    logic         hold_prev = 1'b0;
    logic [127:0] hold_data;
    logic [2:0]   hold_nw;
    logic         flush_seen = 1'b0;

    fifo_block_packer_if #(.DATA_WIDTH(DW), .WORDS_PER_BLOCK(W)) bus ();

    fifo_block_packer #(.DATA_WIDTH(DW), .WORDS_PER_BLOCK(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        @(negedge clk);
        while (!bus.blk_valid_o && n < max) begin
            tick();
            @(negedge clk);
            n++;
        end
        check_val("wait_valid", bus.blk_valid_o, 1);
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        push_en   = 1'b1;
        push_data = d;
        tick();
        push_en   = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
    endtask

    // FIFO model: registered read data, cleared when reset is first asserted.
    always @(posedge clk) begin
        if (!rst && rst_prev) begin
            fq.delete();
            exp_q.delete();
        end else if (bus.fifo_rd_en_o) begin
            if (fq.size() > 0) bus.fifo_rd_data_i <= fq.pop_front();
            else               bus.fifo_rd_data_i <= 32'hDEAD_BEEF;
        end
        if (push_en) begin
            fq.push_back(push_data);
            exp_q.push_back(push_data);
        end
        bus.fifo_empty_i <= (fq.size() == 0);
        rst_prev <= rst;
    end

    // Protocol invariants and block scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check_val("pop_empty", bus.fifo_rd_en_o & bus.fifo_empty_i, 0);
            check_val("pop_in_out", bus.fifo_rd_en_o & bus.blk_valid_o, 0);
            if (hold_prev) begin
                check_val("hold_data", bus.blk_data_o, hold_data);
                check_val("hold_nw", bus.blk_nwords_o, hold_nw);
            end
            if (bus.blk_valid_o && bus.blk_ready_i) begin
                check_val("nw_range", (bus.blk_nwords_o >= 1 && bus.blk_nwords_o <= W), 1);
                if (bus.blk_nwords_o != W) check_val("partial_flush", flush_seen, 1);
                for (int i = 0; i < W; i++) begin
                    if (i < int'(bus.blk_nwords_o)) begin
                        check_val("sb_avail", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0)
                            check_val("blk_word", bus.blk_data_o[i*DW +: DW], exp_q.pop_front());
                    end else begin
                        check_val("blk_pad", bus.blk_data_o[i*DW +: DW], 0);
                    end
                end
                flush_seen = 1'b0;
            end
            if (bus.flush_i) flush_seen = 1'b1;
            hold_prev = bus.blk_valid_o && !bus.blk_ready_i;
            hold_data = bus.blk_data_o;
            hold_nw   = bus.blk_nwords_o;
        end else begin
            hold_prev  = 1'b0;
            flush_seen = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] w [4];
        rst = 1'b0;
        bus.flush_i = 1'b0;
        bus.blk_ready_i = 1'b0;
        tick();

        // Reset with FIFO loading, then latency from first pop.
        for (int i = 0; i < 4; i++) begin
            push_en   = 1'b1;
            push_data = 32'h1111_1111 * (i + 1);
            @(negedge clk);
            check_val("rst_rd_en", bus.fifo_rd_en_o, 0);
            check_val("rst_valid", bus.blk_valid_o, 0);
            check_val("rst_data", bus.blk_data_o, 0);
            check_val("rst_nw", bus.blk_nwords_o, 0);
            tick();
        end
        push_en = 1'b0;
        rst = 1'b1;
        bus.blk_ready_i = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check_val("lat_rd_en", bus.fifo_rd_en_o, (c <= 3));
            check_val("lat_valid", bus.blk_valid_o, (c == 5));
            if (c == 5) begin
                check_val("lat_data", bus.blk_data_o, 128'h44444444_33333333_22222222_11111111);
                check_val("lat_nw", bus.blk_nwords_o, 4);
            end
            tick();
        end

        // Back-pressure: 8 words, consumer stalled for 10 cycles.
        bus.blk_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) push_word(32'h5000_0001 + i);
        wait_valid(20);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_val("bp_rd_en", bus.fifo_rd_en_o, 0);
            check_val("bp_data", bus.blk_data_o, {32'h5000_0004, 32'h5000_0003, 32'h5000_0002, 32'h5000_0001});
            check_val("bp_fifo", fq.size(), 4);
            tick();
        end
        bus.blk_ready_i = 1'b1;
        tick();
        wait_valid(20);
        check_val("bp_data2", bus.blk_data_o, {32'h5000_0008, 32'h5000_0007, 32'h5000_0006, 32'h5000_0005});
        check_val("bp_nw2", bus.blk_nwords_o, 4);
        tick();

        // Partial block flush, then a flush with nothing captured.
        push_word(32'hA);
        push_word(32'hB);
        repeat (3) tick();
        pulse_flush();
        wait_valid(10);
        check_val("fl_data", bus.blk_data_o, {64'h0, 32'hB, 32'hA});
        check_val("fl_nw", bus.blk_nwords_o, 2);
        tick();
        repeat (3) tick();
        pulse_flush();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_val("fl_empty_valid", bus.blk_valid_o, 0);
            tick();
        end

        // Flush with a pop in flight: in the pop cycle and the cycle after.
        for (int off = 0; off < 2; off++) begin
            w[0] = 32'hC000_0000 + off * 16;
            w[1] = w[0] + 1;
            push_word(w[0]);
            repeat (3) tick();
            push_en   = 1'b1;
            push_data = w[1];
            tick();
            push_en = 1'b0;
            if (off == 0) bus.flush_i = 1'b1;
            @(negedge clk);
            check_val("inflight_pop", bus.fifo_rd_en_o, 1);
            tick();
            if (off == 1) begin
                bus.flush_i = 1'b1;
                tick();
            end
            bus.flush_i = 1'b0;
            wait_valid(10);
            check_val("inflight_data", bus.blk_data_o, {64'h0, w[1], w[0]});
            check_val("inflight_nw", bus.blk_nwords_o, 2);
            tick();
        end

        // Trickle: one word every 3 cycles.
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            push_word(w[i]);
            repeat (2) tick();
        end
        wait_valid(10);
        check_val("trk_data", bus.blk_data_o, {w[3], w[2], w[1], w[0]});
        check_val("trk_nw", bus.blk_nwords_o, 4);
        tick();
        repeat (2) tick();

        // Reset with wcnt=3 and a pop in flight.
        for (int c = 0; c < 6; c++) begin
            push_en   = (c < 4);
            push_data = 32'hEE00_0000 + c;
            if (c == 5) rst = 1'b0;
            if (c == 4) begin
                @(negedge clk);
                check_val("mr_pop4", bus.fifo_rd_en_o, 1);
            end
            tick();
        end
        push_en = 1'b0;
        @(negedge clk);
        check_val("mr_valid", bus.blk_valid_o, 0);
        check_val("mr_rd_en", bus.fifo_rd_en_o, 0);
        check_val("mr_data", bus.blk_data_o, 0);
        rst = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_val("mr_idle_valid", bus.blk_valid_o, 0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            w[i] = 32'h7700_0000 + i;
            push_word(w[i]);
        end
        wait_valid(10);
        check_val("mr_fresh", bus.blk_data_o, {w[3], w[2], w[1], w[0]});
        check_val("mr_fresh_nw", bus.blk_nwords_o, 4);
        tick();

        // Random traffic against the word-stream scoreboard.
        for (int c = 0; c < 800; c++) begin
            push_en         = ($urandom_range(0, 1) == 1);
            push_data       = $urandom;
            bus.blk_ready_i = ($urandom_range(0, 3) != 0);
            bus.flush_i     = ($urandom_range(0, 19) == 0);
            tick();
        end
        push_en = 1'b0;
        bus.flush_i = 1'b0;
        bus.blk_ready_i = 1'b1;
        repeat (60) tick();
        pulse_flush();
        repeat (20) tick();
        check_val("drain_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_block_packer.md
Name: fifo_block_packer

Overview:
Consumer stage on the read side of the store-buffer FIFO. Pops DATA_WIDTH-bit words from the FIFO and packs WORDS_PER_BLOCK of them into one wide block for the crypto core, using a valid/ready handshake. A flush request emits a zero-padded partial block at end of message. Pops are fully pipelined against the FIFO's registered read port: one word per cycle.

Parameters:
DATA_WIDTH, 32, FIFO word width in bits.
WORDS_PER_BLOCK, 4, words per output block; must be ≥2. Default gives a 128-bit block.
CNT_W, $clog2(WORDS_PER_BLOCK+1), width of word-count signals (localparam).

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous reset, active-low (0 = reset).
fifo_rd_data_i  in  DATA_WIDTH  FIFO read data; valid one cycle after the pop that selected it.
fifo_empty_i  in  1  FIFO empty flag.
fifo_rd_en_o  out  1  FIFO pop strobe (combinational).
flush_i  in  1  single-cycle request to emit the current partial block.
blk_data_o  out  DATA_WIDTH*WORDS_PER_BLOCK  packed block; word 0 (first popped) in bits [DATA_WIDTH-1:0].
blk_nwords_o  out  CNT_W  number of valid words in blk_data_o (1..WORDS_PER_BLOCK).
blk_valid_o  out  1  block available.
blk_ready_i  in  1  consumer accepts the block.

Behaviour:
- Reset (rst=0 at an edge): state=FILL, wcnt=0, pend=0, flush_pend=0, blk_valid_o=0, blk_data_o=0, blk_nwords_o=0. fifo_rd_en_o=0 while rst=0. A word in flight is discarded. The FIFO must be reset in the same cycle; the top level inverts rst for the FIFO.
- Internal registers:
  - wcnt: words captured so far.
  - pend: a pop was issued last cycle.
  - flush_pend: a flush request is latched.
- fifo_rd_en_o = rst & (state==FILL) & !flush_pend & !fifo_empty_i & (wcnt + pend < WORDS_PER_BLOCK).
- pend is set to fifo_rd_en_o every cycle.
- Capture: if pend=1, fifo_rd_data_i is written to slot wcnt and wcnt increments. Pop-to-capture latency is one cycle.
- States:
  - FILL → OUT when a capture makes wcnt=WORDS_PER_BLOCK. At that edge: blk_valid_o←1, blk_nwords_o←WORDS_PER_BLOCK.
  - FILL → DRAIN when flush_pend=1 or flush_i=1. No new pops in DRAIN.
  - DRAIN, once pend=0:
    - wcnt>0: →OUT, blk_valid_o←1, blk_nwords_o←wcnt, unfilled slots are 0.
    - wcnt=0: →FILL, flush dropped, no block emitted.
    - In both cases flush_pend is cleared.
  - OUT: blk_data_o and blk_nwords_o are held stable while blk_valid_o=1. On blk_valid_o & blk_ready_i: →FILL, blk_valid_o←0, wcnt←0, block register←0. Pops resume in the next cycle.
- Flush arrival:
  - flush_i in OUT: latched into flush_pend. Processed after the handshake; it emits nothing unless words have arrived since.
  - flush_i in the same cycle as the final capture: the full block is emitted normally, then flush_pend is processed (normally a no-op).
  - flush_i in DRAIN: ignored.
- Throughput and latency:
  - Back-to-back full blocks: WORDS_PER_BLOCK pops, then ≥1 cycle in OUT. No pop is issued while in OUT.
  - Latency with W=4, FIFO pre-loaded, ready held high: first pop in cycle 0, blk_valid_o high in cycle 5.
- fifo_empty_i is only sampled for pop gating. Popping an empty FIFO must be impossible.

Test Plan:
- Reset and latency: hold rst=0 for 3 cycles with the FIFO loaded → all outputs 0. Release, FIFO holding 0x11111111..0x44444444, ready=1 → fifo_rd_en_o high cycles 0–3, blk_valid_o high in cycle 5, blk_data_o=0x44444444_33333333_22222222_11111111, blk_nwords_o=4.
- Back-pressure: 8 words preloaded, blk_ready_i=0 for 10 cycles → blk_data_o stable, fifo_rd_en_o=0 and FIFO holds 4 words during the stall. Raise ready → second block 5..8 follows with no word loss or reordering.
- Flush partial block: write 2 words (0xA, 0xB), pulse flush_i → block {0,0,0xB,0xA}, blk_nwords_o=2. A flush with wcnt=0 and no pend → no blk_valid_o.
- Flush during in-flight pop: flush_i in the cycle after a pop → DRAIN waits for the capture, then emits with blk_nwords_o including that word.
- Trickle and empty: FIFO written 1 word every 3 cycles → fifo_rd_en_o never asserts while fifo_empty_i=1. Block emitted after the 4th capture, contents in order.
- Mid-operation reset: rst=0 with wcnt=3 and pend=1 → next cycle wcnt=0, blk_valid_o=0. Fresh 4 words after reset → correct block with no stale data.
